scan_start_sched: RTL
=====================

# scan_start_sched

Scheduler for the two-source scan-start path. Two scan requesters share one scan engine. The block arbitrates between them and drives the `change` select code for the scan-start mux. It waits for the mux to settle, issues a start pulse on the granted source line, waits for end-of-scan (with optional timeout), then parks the mux in hold. It sits in the `dds` clock domain directly upstream of the scan-scale select mux.

## Interface
- `SETTLE`, default 4: cycles between the `change` update and the start pulse (≥1).
- `PULSE_W`, default 2: width of the start pulse, in cycles (≥1).
- `TO_W`, default 16: width of the timeout counter and of `timeout_cyc`.

Ports:
- `dds` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req1`, `req2` in 1: scan request, level, held until `ack1`/`ack2` or withdrawn.
- `ack1`, `ack2` out 1: one-cycle grant acknowledge.
- `scan_done` in 1: single-cycle end-of-scan pulse from the scan engine.
- `timeout_cyc` in `TO_W`: maximum RUN duration in cycles; 0 disables the timeout.
- `clr_err` in 1: clears `timeout_err`.
- `change` out 2: mux select; 2'b00 = source 1, 2'b01 = source 2, 2'b11 = hold.
- `s_startin1`, `s_startin2` out 1: start pulses to mux inputs 1 and 2.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, SELECT, START, RUN, RELEASE. All outputs are registered.
- Reset values: state IDLE, `change` = 2'b11, `s_startin1`/`s_startin2` = 0, `ack1`/`ack2` = 0, `busy` = 0, `timeout_err` = 0, `last_grant` = source 2 (so source 1 wins the first tie).
- **IDLE**
  - One request high: grant that source.
  - Both requests high: grant the source not equal to `last_grant` (round-robin).
  - On a grant: latch `sel`, drive `change` = `sel` code, load the counter with `SETTLE`−1, go to SELECT.
- **SELECT**
  - Decrement the counter.
  - If the granted `req` drops, abort: go to RELEASE with no pulse and no ack.
  - At count 0: go to START, load the counter with `PULSE_W`−1.
- **START**
  - Drive the granted `s_startin` high for exactly `PULSE_W` cycles; the other start line stays 0.
  - Assert the granted `ack` in the first START cycle only.
  - Update `last_grant` = `sel`.
  - After `PULSE_W` cycles: go to RUN, clear the counter.
  - `req` withdrawal is ignored from START onward.
- **RUN**
  - `change` is held.
  - `scan_done` takes RELEASE.
  - Otherwise the counter increments. If `timeout_cyc` ≠ 0 and counter = `timeout_cyc`−1: set `timeout_err`, go to RELEASE.
  - `scan_done` and timeout in the same cycle: done wins, no error.
- **RELEASE**
  - `change` = 2'b11 for one cycle, then IDLE.
  - Requests are not sampled in RELEASE.
- `scan_done` outside RUN is ignored.
- `timeout_err`: set has priority over `clr_err` in the same cycle; otherwise `clr_err` clears it.
- Counter width is max(`TO_W`, clog2(`SETTLE`), clog2(`PULSE_W`)).

## Timing
- Request seen at edge t (IDLE):
  - `change` valid after t+1.
  - First `s_startin` cycle after edge t+1+`SETTLE`.
  - `ack` in that same cycle.
  - The downstream mux registers again, so `s_start` follows one `dds` cycle later.
- Minimum grant-to-grant spacing: `SETTLE` + `PULSE_W` + 1 (RUN) + 1 (RELEASE) + 1 (IDLE) cycles.
- `change` never changes while either `s_startin` is high; it changes only on IDLE→SELECT and on entering RELEASE.
- `rst_n` low at any edge, including mid-pulse or mid-RUN:
  - All outputs take their reset values on that edge and the pulse is truncated.
  - `timeout_err` clears.

## Test plan
- **Single request.** `SETTLE`=4, `PULSE_W`=2; `req1` held from cycle 0.
  - `change`=00 from cycle 1.
  - `s_startin1`=1 in cycles 5–6; `ack1` in cycle 5 only.
  - `scan_done` at cycle 10 → `change`=11 in cycle 11, IDLE at cycle 12.
- **Tie and round-robin.** `req1` and `req2` high together from reset.
  - Source 1 is granted first.
  - Both re-requested after its done → source 2 granted next (`change`=01, `s_startin2` pulse, `ack2`).
- **Withdraw during SELECT.** `req2` drops in the second SELECT cycle.
  - No `s_startin2`, no `ack2`.
  - `change` returns to 11 the next cycle, then IDLE.
- **Timeout.** `timeout_cyc`=8, `scan_done` never arrives.
  - `timeout_err`=1 after the 8th RUN cycle, then RELEASE.
  - `clr_err` pulse → 0.
  - With `timeout_cyc`=0, RUN persists indefinitely.
- **Done/timeout collision.** `scan_done` in the same cycle the timeout fires → `timeout_err` stays 0.
- **Reset mid-operation.** `rst_n`=0 in the first START cycle.
  - Next edge: `s_startin1`=0, `change`=11, `busy`=0.
  - After release, `req1` is re-granted normally.

Source files
------------

// File: rtl/scan_start_sched_if.sv
// Handshake and control bundle between the two scan requesters, the scan engine
// and the scan-start scheduler.
interface scan_start_sched_if #(
  parameter int TO_W = 16
);
  logic            req1;
  logic            req2;
  logic            ack1;
  logic            ack2;
  logic            scan_done;
  logic [TO_W-1:0] timeout_cyc;
  logic            clr_err;
  logic [1:0]      change;
  logic            s_startin1;
  logic            s_startin2;
  logic            busy;
  logic            timeout_err;

  // Requesters / scan engine side
  modport master (
    output req1, req2, scan_done, timeout_cyc, clr_err,
    input  ack1, ack2, change, s_startin1, s_startin2, busy, timeout_err
  );

  // Scheduler side
  modport slave (
    input  req1, req2, scan_done, timeout_cyc, clr_err,
    output ack1, ack2, change, s_startin1, s_startin2, busy, timeout_err
  );
endinterface

// File: rtl/scan_start_sched.sv
// Two-source scan-start scheduler: round-robin grant, mux settle, start pulse,
// end-of-scan wait with optional timeout, then park the mux in hold.
module scan_start_sched #(
  parameter int SETTLE  = 4,
  parameter int PULSE_W = 2,
  parameter int TO_W    = 16
) (
  input logic               dds,
  input logic               rst_n,
  scan_start_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam int CW_S = (SETTLE  > 1) ? $clog2(SETTLE)  : 1;
  localparam int CW_P = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int CW_SP = (CW_S > CW_P) ? CW_S : CW_P;
  localparam int CW   = (TO_W > CW_SP) ? TO_W : CW_SP;

  localparam logic [1:0] CHG_SRC1 = 2'b00;
  localparam logic [1:0] CHG_SRC2 = 2'b01;
  localparam logic [1:0] CHG_HOLD = 2'b11;

  logic [2:0]    r_state;
  logic          r_sel;         // 0 = source 1, 1 = source 2
  logic          r_last_grant;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_change;
  logic          r_start1;
  logic          r_start2;
  logic          r_ack1;
  logic          r_ack2;
  logic          r_busy;
  logic          r_err;

  logic          w_any_req;
  logic          w_grant_sel;
  logic          w_sel_req;
  logic [CW-1:0] w_to_last;
  logic          w_to_hit;
  logic          w_to_fire;

  always_comb begin
    w_any_req   = bus.req1 | bus.req2;
    w_grant_sel = (bus.req1 && bus.req2) ? ~r_last_grant : ~bus.req1;
    w_sel_req   = r_sel ? bus.req2 : bus.req1;
    w_to_last   = CW'(bus.timeout_cyc) - CW'(1);
    w_to_hit    = (bus.timeout_cyc != '0) && (r_cnt == w_to_last);
    // A same-cycle scan_done takes precedence and suppresses the error.
    w_to_fire   = (r_state == S_RUN) && !bus.scan_done && w_to_hit;
  end

  always_ff @(posedge dds) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_change     <= CHG_HOLD;
      r_start1     <= 1'b0;
      r_start2     <= 1'b0;
      r_ack1       <= 1'b0;
      r_ack2       <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ack1 <= 1'b0;
      r_ack2 <= 1'b0;

      if (w_to_fire)
        r_err <= 1'b1;
      else if (bus.clr_err)
        r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel    <= w_grant_sel;
            r_change <= w_grant_sel ? CHG_SRC2 : CHG_SRC1;
            r_cnt    <= CW'(SETTLE - 1);
            r_busy   <= 1'b1;
            r_state  <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (!w_sel_req) begin
            r_change <= CHG_HOLD;
            r_state  <= S_RELEASE;
          end else if (r_cnt == '0) begin
            // Pulse, ack and grant history all registered on entry to START.
            r_cnt        <= CW'(PULSE_W - 1);
            r_start1     <= ~r_sel;
            r_start2     <= r_sel;
            r_ack1       <= ~r_sel;
            r_ack2       <= r_sel;
            r_last_grant <= r_sel;
            r_state      <= S_START;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_START: begin
          if (r_cnt == '0) begin
            r_start1 <= 1'b0;
            r_start2 <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_RUN: begin
          if (bus.scan_done || w_to_hit) begin
            r_change <= CHG_HOLD;
            r_state  <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_change <= CHG_HOLD;
          r_start1 <= 1'b0;
          r_start2 <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack1        = r_ack1;
  assign bus.ack2        = r_ack2;
  assign bus.change      = r_change;
  assign bus.s_startin1  = r_start1;
  assign bus.s_startin2  = r_start2;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_err;

endmodule
